// File: rtl/sme_str_mem_arbiter_pkg.sv
// sme_str_mem_arbiter_pkg: shared defaults and helpers for the string-buffer arbiter
package sme_str_mem_arbiter_pkg;
  localparam int SME_NUM_PE      = 4;
  localparam int SME_MAX_STR_ADD = 5;
  localparam int SME_CHAR_W      = 8;
  localparam int SME_MEM_RD_LAT  = 1;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/sme_str_mem_arbiter_rr_picker.sv
// sme_rr_picker: rotate-priority encoder, first requester at or above ptr with wrap
module sme_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/sme_str_mem_arbiter.sv
// sme_str_mem_arbiter: shares the string SRAM between host writes and round-robin PE reads
module sme_str_mem_arbiter
  import sme_str_mem_arbiter_pkg::*;
#(
  parameter int NUM_PE = SME_NUM_PE,
  parameter int ADDR_W = SME_MAX_STR_ADD,
  parameter int DATA_W = SME_CHAR_W,
  parameter int RD_LAT = SME_MEM_RD_LAT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arb_en,
  input  logic                     host_wr_en,
  input  logic [ADDR_W-1:0]        host_wr_addr,
  input  logic [DATA_W-1:0]        host_wr_data,
  input  logic [NUM_PE-1:0]        pe_req,
  input  logic [NUM_PE*ADDR_W-1:0] pe_addr,
  output logic [NUM_PE-1:0]        pe_gnt,
  output logic [NUM_PE-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     idle
);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  logic [PW-1:0]                   rr_q, rr_d, pick_idx;
  logic [NUM_PE-1:0]               pick_gnt;
  logic                            rd_go;
  logic [RD_LAT-1:0][NUM_PE-1:0]   tag_q;
  sme_rr_picker #(.N(NUM_PE), .IW(PW)) u_pick (
    .req(pe_req),
    .ptr(rr_q),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  // host write beats PE reads; everything is forced quiet while reset is high
  always_comb begin
    rd_go     = ~reset & ~host_wr_en & arb_en & |pe_req;
    pe_gnt    = rd_go ? pick_gnt : '0;
    mem_en    = ~reset & (host_wr_en | rd_go);
    mem_we    = ~reset & host_wr_en;
    mem_addr  = mem_we ? host_wr_addr : rd_go ? pe_addr[ADDR_W*int'(pick_idx) +: ADDR_W] : '0;
    mem_wdata = mem_we ? host_wr_data : '0;
    rr_d      = rd_go ? PW'(wrap_inc(int'(pick_idx), NUM_PE)) : rr_q;
    idle      = reset | (~|tag_q & ~|pe_req);
  end
  // pointer update, tag shift register matched to SRAM latency, response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= '0;
      tag_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rr_q     <= rr_d;
      tag_q[0] <= pe_gnt;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid <= tag_q[RD_LAT-1];
      if (|tag_q[RD_LAT-1]) rsp_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_sme_str_mem_arbiter.sv
// tb_sme_str_mem_arbiter: scoreboard bench driving RD_LAT=1 and RD_LAT=3 arbiters in lockstep
module tb_sme_str_mem_arbiter;
  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] d;
    int         due;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset = 1'b1, arb_en = 1'b0, host_wr_en = 1'b0;
  logic [4:0]  host_wr_addr = '0;
  logic [7:0]  host_wr_data = '0;
  logic [3:0]  pe_req = '0;
  logic [19:0] pe_addr = '0;
  logic [3:0]  gnt_w [2];
  logic [3:0]  rv_w [2];
  logic        men_w [2], mwe_w [2], idle_w [2];
  logic [4:0]  maddr_w [2];
  logic [7:0]  mwd_w [2], rd_w [2], rdat_w [2];
  int checks = 0, fails = 0, cyc = 0;
  logic       push_v = 1'b0;
  logic [3:0] push_oh = '0;
  logic [7:0] push_d = '0;
  int         push_c = 0;
  logic [7:0] mem_m [32];
  int         rr_m = 0;
  logic [3:0] gnt_m = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 1) ? 3 : 1;
    logic [7:0] sram [32];
    logic [7:0] pipe [L];
    exp_t q [$];
    exp_t e;
    sme_str_mem_arbiter #(.NUM_PE(4), .ADDR_W(5), .DATA_W(8), .RD_LAT(L)) dut (
      .clk(clk), .reset(reset), .arb_en(arb_en),
      .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .pe_req(pe_req), .pe_addr(pe_addr), .pe_gnt(gnt_w[g]),
      .rsp_valid(rv_w[g]), .rsp_data(rdat_w[g]),
      .mem_en(men_w[g]), .mem_we(mwe_w[g]), .mem_addr(maddr_w[g]), .mem_wdata(mwd_w[g]),
      .mem_rdata(rd_w[g]), .idle(idle_w[g])
    );
    always @(posedge clk) begin
      if (men_w[g] && mwe_w[g]) sram[maddr_w[g]] <= mwd_w[g];
      pipe[0] <= (men_w[g] && !mwe_w[g]) ? sram[maddr_w[g]] : 8'hEE;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_w[g] = pipe[L-1];
    initial forever begin
      @(posedge clk);
      if (push_v) q.push_back('{push_oh, push_d, push_c + L + 1});
      #3;
      if (rv_w[g] != 4'b0) begin
        if (q.size() == 0) chk($sformatf("rsp_unexpected[L%0d]", L), 32'(rv_w[g]), 32'd0);
        else begin
          e = q.pop_front();
          chk($sformatf("rsp_onehot[L%0d]", L), 32'(rv_w[g]), 32'(e.oh));
          chk($sformatf("rsp_data[L%0d]", L), 32'(rdat_w[g]), 32'(e.d));
          chk($sformatf("rsp_cycle[L%0d]", L), 32'(cyc), 32'(e.due));
        end
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        chk($sformatf("rsp_missing[L%0d]", L), 32'(rv_w[g]), 32'(q[0].oh));
        void'(q.pop_front());
      end
      if (reset) q.delete();
      chk($sformatf("idle[L%0d]", L), 32'(idle_w[g]), 32'(reset || (q.size() == 0 && pe_req == 4'b0)));
    end
  end
  function automatic logic [19:0] rep(input logic [4:0] a);
    return {4{a}};
  endfunction
  task automatic step(input logic r, input logic en, input logic hw, input logic [4:0] ha,
                      input logic [7:0] hd, input logic [3:0] rq, input logic [19:0] ad);
    int k;
    logic [4:0] ea;
    reset = r; arb_en = en; host_wr_en = hw; host_wr_addr = ha; host_wr_data = hd;
    pe_req = rq; pe_addr = ad;
    @(negedge clk);
    k = -1;
    if (!r && !hw && en)
      for (int o = 0; o < 4; o++) if (k < 0 && rq[(rr_m + o) % 4]) k = (rr_m + o) % 4;
    gnt_m = (k < 0) ? 4'b0 : 4'(1 << k);
    ea = r ? 5'd0 : hw ? ha : (k >= 0) ? ad[k*5 +: 5] : 5'd0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("pe_gnt[%0d]", g), 32'(gnt_w[g]), 32'(gnt_m));
      chk($sformatf("mem_en[%0d]", g), 32'(men_w[g]), 32'(!r && (hw || k >= 0)));
      chk($sformatf("mem_we[%0d]", g), 32'(mwe_w[g]), 32'(!r && hw));
      if (r || hw || k >= 0) chk($sformatf("mem_addr[%0d]", g), 32'(maddr_w[g]), 32'(ea));
      if (r || hw) chk($sformatf("mem_wdata[%0d]", g), 32'(mwd_w[g]), r ? 32'd0 : 32'(hd));
    end
    push_v = (k >= 0);
    if (k >= 0) begin
      push_oh = gnt_m;
      push_d  = mem_m[ad[k*5 +: 5]];
      push_c  = cyc;
      rr_m    = (k + 1) % 4;
    end
    if (r) rr_m = 0;
    else if (hw) mem_m[ha] = hd;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b0, 20'd0);
  endtask
  task automatic rst1();
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 4'b0, 20'd0);
  endtask
  logic [3:0]  rq_s = '0;
  logic [19:0] ad_s = '0;
  initial begin
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    repeat (3) rst1();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_rsp_valid[%0d]", g), 32'(rv_w[g]), 32'd0);
      chk($sformatf("reset_rsp_data[%0d]", g), 32'(rdat_w[g]), 32'd0);
    end
    for (int a = 0; a < 32; a++)
      step(1'b0, 1'b1, 1'b1, 5'(a), (a == 5) ? 8'h41 : 8'($urandom), 4'b0, 20'd0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b0010, rep(5'd5));
    quiet(5);
    rst1();
    repeat (5) step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b1111, {5'd9, 5'd7, 5'd5, 5'd3});
    quiet(5);
    rst1();
    repeat (2) step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b1111, rep(5'd11));
    step(1'b0, 1'b1, 1'b1, 5'd3, 8'h5A, 4'b1111, rep(5'd3));
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b1111, rep(5'd3));
    quiet(5);
    rst1();
    repeat (3) step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 4'b1001, rep(5'd7));
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b1001, rep(5'd7));
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b0100, rep(5'd9));
    rst1();
    quiet(5);
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b1111, rep(5'd13));
    quiet(5);
    rst1();
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b1000, {5'd20, 5'd0, 5'd0, 5'd0});
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b0011, {5'd0, 5'd0, 5'd22, 5'd21});
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 4'b0010, {5'd0, 5'd0, 5'd22, 5'd0});
    quiet(6);
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 4; i++)
        if (!rq_s[i] && $urandom_range(0, 2) == 0) begin
          rq_s[i] = 1'b1;
          ad_s[i*5 +: 5] = 5'($urandom);
        end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           5'($urandom), 8'($urandom), rq_s, ad_s);
      rq_s &= ~gnt_m;
    end
    quiet(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sme_str_mem_arbiter.md
Name: sme_str_mem_arbiter

Overview:
- Shares the single-port string buffer SRAM between the NUM_PE KMP processing elements and the host string loader.
- Host writes take priority. PE reads are granted one per cycle, round-robin.
- Each read response is returned to its requester through a tagged, latency-matched pipeline.
- Sits between the PE array and the string SRAM. The KMP control unit gates it through arb_en, which is driven from pe_valid.

Parameters:
- NUM_PE, 4, number of requesting PEs (matches `NUM_PE).
- ADDR_W, 5, string address width (matches `MAX_STR_ADD).
- DATA_W, 8, character width.
- RD_LAT, 1, SRAM read latency in cycles, legal range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- arb_en  in  1  read arbitration enable (from control unit pe_valid)
- host_wr_en  in  1  host string write strobe
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write character
- pe_req  in  NUM_PE  per-PE read request, held until granted
- pe_addr  in  NUM_PE*ADDR_W  per-PE read address, PE i at [i*ADDR_W +: ADDR_W]
- pe_gnt  out  NUM_PE  one-hot grant, combinational, same cycle as request
- rsp_valid  out  NUM_PE  one-hot response strobe, registered
- rsp_data  out  DATA_W  response character, shared by all PEs, registered
- mem_en  out  1  SRAM enable, combinational
- mem_we  out  1  SRAM write enable, combinational
- mem_addr  out  ADDR_W  SRAM address, combinational
- mem_wdata  out  DATA_W  SRAM write data, combinational
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read enable
- idle  out  1  high when no read is in flight and pe_req == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - Registered outputs: rsp_valid=0, rsp_data=0.
  - Internal state: rr_ptr=0, tag pipeline cleared.
  - While reset is high, combinational outputs are forced: pe_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, idle=1.
- Priority per cycle:
  1. host_wr_en: mem_en=1, mem_we=1, mem_addr=host_wr_addr, mem_wdata=host_wr_data. pe_gnt=0 and rr_ptr is held.
  2. Otherwise, if arb_en && |pe_req: grant k, the first requesting index found searching upward from rr_ptr with wrap modulo NUM_PE.
     - pe_gnt[k]=1, mem_en=1, mem_we=0, mem_addr=pe_addr[k].
     - rr_ptr <= (k+1) mod NUM_PE.
  3. Otherwise: mem_en=0, pe_gnt=0, rr_ptr held.
- Fairness: a continuously requesting PE is granted within NUM_PE cycles in which no host write occurs.
- Request rule: a PE drops or changes pe_req and pe_addr only in the cycle after pe_gnt. An ungranted request stays pending, with no internal queue.
- Tag pipeline:
  - A grant pushes {valid=1, onehot=pe_gnt} into an RD_LAT-deep shift register. Non-grant cycles push valid=0.
  - When the tag reaches the final stage, on the next clk: rsp_valid <= onehot and rsp_data <= mem_rdata.
  - Otherwise rsp_valid <= 0 and rsp_data holds its last value.
- Latency: rsp_valid is asserted exactly RD_LAT+1 cycles after the grant cycle. Full throughput: one response per cycle, in grant order.
- A write and a read to the same address in the same cycle: the write wins and the read is retried next cycle. A read granted after the write returns the new data.
- arb_en deasserted with reads in flight: in-flight responses still complete and no new grants are issued.
- Reset mid-operation: in-flight reads are dropped (no rsp_valid after reset) and rr_ptr returns to 0.
- idle = ~|tag_valid_stages && ~|pe_req.
- pe_addr values are used unmodified. Out-of-range addresses are the requester's responsibility.

Decomposition:
- SME_spec_param.v gains `CHAR_W (8) and `MEM_RD_LAT (1), next to the existing `NUM_PE and `MAX_STR_ADD.
- The top-level module defaults its parameters from these defines.
- One sub-module: sme_rr_picker, a combinational rotate-priority encoder. Inputs are req and ptr. Outputs are the one-hot gnt and the index.
- The tag pipeline and the mux stay in the top-level module.

Test Plan:
- Single read (RD_LAT=1): mem[5]=0x41; pe_req=4'b0010, pe_addr[1]=5, arb_en=1 at cycle t -> pe_gnt=4'b0010 at t, mem_addr=5 at t, rsp_valid=4'b0010 with rsp_data=0x41 at t+2.
- Round-robin: pe_req=4'b1111 held, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, and responses return in the same order.
- Host priority: host_wr_en=1 (addr 3, data 0x5A) with pe_req=4'b1111 and rr_ptr=2 -> pe_gnt=0, mem_we=1. Next cycle PE2 is granted. A read of addr 3 returns 0x5A.
- Gating: arb_en=0 with pe_req=4'b1001 -> pe_gnt=0 and mem_en=0 for all cycles. Raising arb_en grants PE0 in the same cycle.
- Reset flush: reset asserted at t+1 after a grant at t -> rsp_valid stays 0 through t+5, idle=1, and the first grant after reset goes to PE0.
- RD_LAT=3: back-to-back grants to PE3, PE0, PE1 -> rsp_valid is 4'b1000, 4'b0001, 4'b0010 at grant+4 cycles each, with matching data.
